// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
//   Receives 8N1-style UART frames on rx. Each accepted word is packed into
//   a wide output beat of NUM_WORDS words, with the first word received in
//   the least significant slot. The finished beat is presented on a
//   valid/ready output. Reception continues while a beat waits for
//   m_ready: the words of the next beat collect in a separate assembly
//   register.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   rx         in   asynchronous serial line, idle high
//   m_data     out  packed beat, word k at [k*BITS_PER_WORD +: BITS_PER_WORD]
//   m_valid    out  m_data holds a complete beat
//   m_ready    in   downstream accepts the beat this cycle
//   frame_err  out  one-cycle pulse when a stop bit is sampled low
//   overflow   out  one-cycle pulse when a word is dropped (output blocked)
// -----------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int CLOCKS_PER_PULSE = 4,   // even, >= 4
    parameter int BITS_PER_WORD    = 8,
    parameter int NUM_WORDS        = 72
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx,
    output logic [NUM_WORDS*BITS_PER_WORD-1:0] m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               frame_err,
    output logic                               overflow
);

    localparam int CNT_W  = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W  = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WC_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BEAT_W = NUM_WORDS * BITS_PER_WORD;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_rx_meta;
    logic                     r_rx_s;
    logic [CNT_W-1:0]         r_cnt;
    logic [BIT_W-1:0]         r_bit_idx;
    logic [BITS_PER_WORD-1:0] r_shift;
    logic [WC_W-1:0]          r_word_cnt;
    logic [BEAT_W-1:0]        r_asm;
    logic [BEAT_W-1:0]        r_m_data;
    logic                     r_m_valid;
    logic                     r_frame_err;
    logic                     r_overflow;

    logic                     w_cnt_clr;
    logic                     w_sample;
    logic                     w_word_done;
    logic                     w_frame_err;
    logic                     w_beat_last;
    logic [BEAT_W-1:0]        w_beat;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_sample     = 1'b0;
        w_word_done  = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_next_state = S_START;
                    w_cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                // Half a bit in: still low means a real start bit.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_bit_idx == BIT_LAST) w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_s) begin
                        w_word_done  = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_next_state = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held break must not be re-read as a stream of start bits.
                if (r_rx_s) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Bit timing and serial-to-parallel shift (LSB arrives first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state == S_IDLE) begin
                r_bit_idx <= '0;
            end else if (w_sample) begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_shift   <= {r_rx_s, r_shift[BITS_PER_WORD-1:1]};
            end
        end
    end

    // Completed beat = collected lower words plus the word arriving now.
    always_comb begin
        w_beat = r_asm;
        w_beat[BEAT_W-BITS_PER_WORD +: BITS_PER_WORD] = r_shift;
    end

    assign w_beat_last = (r_word_cnt == WORD_LAST);

    // NOTE: the beat and assembly registers are reset like any other state so
    // m_data reads zero after reset rather than stale words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt  <= '0;
            r_asm       <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overflow  <= 1'b0;
            if (r_m_valid && m_ready) r_m_valid <= 1'b0;
            if (w_word_done) begin
                if (!w_beat_last) begin
                    r_asm[int'(r_word_cnt) * BITS_PER_WORD +: BITS_PER_WORD] <= r_shift;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end else if (!r_m_valid || m_ready) begin
                    // Output free, or freed by this cycle's handshake.
                    r_m_data   <= w_beat;
                    r_m_valid  <= 1'b1;
                    r_word_cnt <= '0;
                end else begin
                    // Blocked: drop the closing word and keep the slot open.
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deserializer
//   Scoreboard bench for uart_rx_deserializer with 4 words per beat and
//   4 clocks per bit. Expected beats are queued as frames are sent and
//   compared whenever the DUT hands a beat over (m_valid && m_ready).
// -----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int CPP = 4;
    localparam int BPW = 8;
    localparam int NW  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx = 1'b1;
    logic              m_ready = 1'b0;
    logic [NW*BPW-1:0] m_data;
    logic              m_valid;
    logic              frame_err;
    logic              overflow;

    int                n_checks = 0;
    int                n_fail = 0;
    logic [31:0]       exp_q[$];
    int                fe_cnt = 0;
    int                ov_cnt = 0;
    int                valid_cycles = 0;

    uart_rx_deserializer #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD   (BPW),
        .NUM_WORDS       (NW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overflow)  ov_cnt++;
            if (m_valid)   valid_cycles++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("beat_unexpected", 64'(exp_q.size()), 64'd1);
                else                   check("beat_data", 64'(m_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        tick(CPP);
        for (int i = 0; i < BPW; i++) begin
            rx = b[i];
            tick(CPP);
        end
        rx = stop_bit;
        tick(CPP);
        rx = 1'b1;
        tick(3);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!m_valid && k < budget) begin
            tick();
            k++;
        end
        check("valid_timeout", 64'(m_valid), 64'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          bad;
        int          fe0;
        int          ov0;

        // Reset state
        tick(3);
        check("rst_m_valid",   64'(m_valid),   64'd0);
        check("rst_m_data",    64'(m_data),    64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        rst = 1'b0;
        tick(3);

        // Basic beat with m_ready high: m_valid lasts one cycle
        m_ready      = 1'b1;
        valid_cycles = 0;
        exp_q.push_back(32'h44332211);
        send_frame(8'h11); send_frame(8'h22); send_frame(8'h33); send_frame(8'h44);
        drain("basic_drain", 50);
        tick(5);
        check("basic_valid_cycles", 64'(valid_cycles), 64'd1);

        // Backpressure: beat held for 100 cycles, cleared on the handshake edge
        m_ready = 1'b0;
        exp_q.push_back(32'h44332211);
        send_frame(8'h11); send_frame(8'h22); send_frame(8'h33); send_frame(8'h44);
        wait_valid(50);
        held = m_data;
        bad  = 0;
        repeat (100) begin
            tick();
            if (m_data !== held || m_valid !== 1'b1) bad++;
        end
        check("hold_data",   64'(held), 64'h44332211);
        check("hold_stable", 64'(bad),  64'd0);
        m_ready = 1'b1;
        tick();
        check("hold_valid_clear", 64'(m_valid), 64'd0);
        check("hold_popped", 64'(exp_q.size()), 64'd0);

        // Framing error: bad frame dropped, following four form the beat
        fe0 = fe_cnt;
        exp_q.push_back(32'h04030201);
        send_frame(8'hA5, 1'b0);
        send_frame(8'h01); send_frame(8'h02); send_frame(8'h03); send_frame(8'h04);
        drain("ferr_drain", 50);
        check("ferr_pulses", 64'(fe_cnt - fe0), 64'd1);

        // Short low glitch is rejected and does not count as a word
        fe0 = fe_cnt;
        rx  = 1'b0;
        tick(2);
        rx  = 1'b1;
        tick(10);
        check("glitch_no_ferr", 64'(fe_cnt - fe0), 64'd0);
        exp_q.push_back(32'h40302010);
        send_frame(8'h10); send_frame(8'h20); send_frame(8'h30); send_frame(8'h40);
        drain("glitch_drain", 50);

        // Overflow: second beat completes while the first is still held
        m_ready = 1'b0;
        ov0     = ov_cnt;
        exp_q.push_back(32'h04030201);
        for (int i = 1; i <= 7; i++) send_frame(8'(i));
        check("ovf_none_early", 64'(ov_cnt - ov0), 64'd0);
        send_frame(8'h08);
        check("ovf_pulse", 64'(ov_cnt - ov0), 64'd1);
        check("ovf_beat_held", 64'(m_data), 64'h04030201);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("ovf_beat_popped", 64'(exp_q.size()), 64'd0);
        exp_q.push_back(32'h09070605);
        send_frame(8'h09);
        wait_valid(50);
        m_ready = 1'b1;
        drain("ovf_drain", 50);
        check("ovf_no_more", 64'(ov_cnt - ov0), 64'd1);

        // Reset mid-beat and mid-frame discards partial words
        send_frame(8'h55); send_frame(8'h66);
        rx = 1'b0;
        tick(10);
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        check("rst2_m_valid", 64'(m_valid), 64'd0);
        check("rst2_m_data",  64'(m_data),  64'd0);
        rst = 1'b0;
        tick(3);
        exp_q.push_back(32'hDDCCBBAA);
        send_frame(8'hAA); send_frame(8'hBB); send_frame(8'hCC); send_frame(8'hDD);
        drain("rst2_drain", 50);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 4, meaning clock cycles per UART bit; even, >= 4.
REQ-002 SHALL have parameter BITS_PER_WORD, default 8, meaning data bits per UART frame.
REQ-003 SHALL have parameter NUM_WORDS, default 72, meaning frames packed into one output beat (8x8 matrix of 8-bit values plus 8-element 8-bit vector).
REQ-004 SHALL have port clk  input  1  meaning sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port rx  input  1  meaning asynchronous serial line, idle high.
REQ-007 SHALL have port m_data  output  NUM_WORDS*BITS_PER_WORD  meaning packed output beat.
REQ-008 SHALL have port m_valid  output  1  meaning m_data holds a complete beat.
REQ-009 SHALL have port m_ready  input  1  meaning downstream accepts the beat this cycle.
REQ-010 SHALL have port frame_err  output  1  meaning one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port overflow  output  1  meaning one-cycle pulse when a word is dropped because the output is blocked.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer reset to 1; all decisions use the synchronized value rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH with a bit-period counter and a bit index.
REQ-014 IDLE: rx_s==0 SHALL go to START with counter cleared.
REQ-015 START: after CLOCKS_PER_PULSE/2 cycles SHALL re-sample rx_s; 0 -> DATA with counter cleared, 1 -> IDLE (glitch rejected, no output).
REQ-016 DATA: SHALL sample rx_s every CLOCKS_PER_PULSE cycles (bit centre), LSB first, BITS_PER_WORD samples, then go to STOP.
REQ-017 STOP: after CLOCKS_PER_PULSE cycles SHALL sample rx_s; 1 -> word accepted and IDLE; 0 -> frame_err pulse, word discarded, WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL stay until rx_s==1, then IDLE (a held break line produces exactly one frame_err).
REQ-019 Accepted word k of a beat (k = 0 first received) SHALL be stored at m_data[k*BITS_PER_WORD +: BITS_PER_WORD].
REQ-020 When word NUM_WORDS-1 is accepted, m_valid SHALL rise on the next clock edge and the word counter SHALL wrap to 0.
REQ-021 m_data and m_valid SHALL remain stable while m_valid==1 and m_ready==0.
REQ-022 m_valid SHALL clear on the edge where m_valid && m_ready; m_ready while m_valid==0 SHALL have no effect.
REQ-023 Reception SHALL continue while m_valid==1; words of the next beat SHALL go to a separate assembly register, leaving m_data unchanged.
REQ-024 If the next beat completes while the previous beat is still unaccepted, the last word SHALL be dropped, overflow SHALL pulse, and the word counter SHALL stay at NUM_WORDS-1.
REQ-025 Simultaneous handshake and next-beat completion in one cycle SHALL load the new beat with m_valid staying 1 and no overflow.
REQ-026 A framing error SHALL not advance the word counter; already-collected words of the beat SHALL be kept.
REQ-027 Latency SHALL be at most 2 (sync) + 1 cycles from the stop-bit sample point to m_valid high.

Reset
REQ-028 On rst: state IDLE, counters 0, synchronizer 1, m_data 0, m_valid 0, frame_err 0, overflow 0.
REQ-029 Reset asserted mid-frame or mid-beat SHALL discard all partial words; the first full frame after release is word 0.

Verification
REQ-030 NUM_WORDS=4, CLOCKS_PER_PULSE=4; send frames 0x11,0x22,0x33,0x44 with m_ready=1 -> m_data=0x44332211, m_valid high exactly 1 cycle.
REQ-031 Same frames, m_ready=0 for 100 cycles -> m_data held at 0x44332211, m_valid held; raise m_ready -> m_valid clears next edge.
REQ-032 Frame 0xA5 with stop bit 0, then 0x01..0x04 -> frame_err one pulse; m_data=0x04030201.
REQ-033 2-cycle low glitch on rx in IDLE -> no frame_err, no word counted, FSM back in IDLE.
REQ-034 m_ready=0, send 8 frames 0x01..0x08 -> first beat 0x04030201 held, overflow one pulse on frame 0x08; after m_ready pulse, next completed word fills last slot.
REQ-035 Assert rst after 2 of 4 words, release, send 4 frames 0xAA,0xBB,0xCC,0xDD -> m_data=0xDDCCBBAA.
